md5_match: RTL and testbench

- Downstream consumer of the md5core pipeline.
- Tracks each message injected into the 64-stage core with a sequence index, using a tag delay line that advances in lock-step with the core.
- Compares each emerging digest against a target hash and captures the index of the first match.
- Reports search completion to the host-side controller.

---
 rtl/md5_match.sv | 128 ++++++++++++
 tb/tb_md5_match.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_match.sv
// Digest matcher for the md5core pipeline: tags every accepted message with its sequence
// index, follows it through the core in lock-step and captures the first digest equal to the target.
module md5_match #(
    parameter int unsigned LATENCY = 65,
    parameter int unsigned IDX_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             start,
    input  logic             mesg_valid,
    input  logic             mesg_last,
    input  logic [127:0]     target_hash,
    input  logic [31:0]      a_in,
    input  logic [31:0]      b_in,
    input  logic [31:0]      c_in,
    input  logic [31:0]      d_in,
    output logic             busy,
    output logic             match_found,
    output logic [IDX_W-1:0] match_index,
    output logic             done,
    output logic [IDX_W-1:0] checked_count
);

    typedef enum logic [1:0] {StIdle, StRun, StFound, StDone} state_e;

    state_e             r_state, w_state_d;
    logic               r_match_found, w_match_found_d;
    logic [IDX_W-1:0]   r_match_index, w_match_index_d;
    logic               r_done, w_done_d;
    logic [IDX_W-1:0]   r_checked_count, w_checked_count_d;
    logic [IDX_W-1:0]   r_idx_cnt, w_idx_cnt_d;

    logic [LATENCY-1:0] r_tag_vld;
    logic [LATENCY-1:0] r_tag_last;
    logic [IDX_W-1:0]   r_tag_idx [LATENCY];

    logic               w_head_vld;
    logic               w_hit;
    logic               w_eval;

    // Only messages accepted while searching get a valid tag.
    assign w_head_vld = mesg_valid && (r_state == StRun);
    assign w_hit      = ({a_in, b_in, c_in, d_in} == target_hash);
    assign w_eval     = en && r_tag_vld[LATENCY-1];

    always_comb begin
        w_state_d         = r_state;
        w_match_found_d   = r_match_found;
        w_match_index_d   = r_match_index;
        w_done_d          = r_done;
        w_checked_count_d = r_checked_count;
        w_idx_cnt_d       = r_idx_cnt;
        case (r_state)
            StRun: begin
                if (en && mesg_valid) begin
                    w_idx_cnt_d = r_idx_cnt + IDX_W'(1);
                end
                if (w_eval) begin
                    w_checked_count_d = r_checked_count + IDX_W'(1);
                    if (w_hit) begin
                        w_match_index_d = r_tag_idx[LATENCY-1];
                        w_match_found_d = 1'b1;
                        w_done_d        = 1'b1;
                        w_state_d       = StFound;
                    end else if (r_tag_last[LATENCY-1]) begin
                        w_done_d  = 1'b1;
                        w_state_d = StDone;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_state_d         = StRun;
                    w_match_found_d   = 1'b0;
                    w_match_index_d   = '0;
                    w_done_d          = 1'b0;
                    w_checked_count_d = '0;
                    w_idx_cnt_d       = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= StIdle;
            r_match_found   <= 1'b0;
            r_match_index   <= '0;
            r_done          <= 1'b0;
            r_checked_count <= '0;
            r_idx_cnt       <= '0;
        end else begin
            r_state         <= w_state_d;
            r_match_found   <= w_match_found_d;
            r_match_index   <= w_match_index_d;
            r_done          <= w_done_d;
            r_checked_count <= w_checked_count_d;
            r_idx_cnt       <= w_idx_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_vld <= '0;
        end else if (en) begin
            r_tag_vld <= {r_tag_vld[LATENCY-2:0], w_head_vld};
        end
    end

    // Payload is meaningless without its valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            r_tag_last   <= {r_tag_last[LATENCY-2:0], mesg_last};
            r_tag_idx[0] <= r_idx_cnt;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    assign busy          = (r_state == StRun);
    assign match_found   = r_match_found;
    assign match_index   = r_match_index;
    assign done          = r_done;
    assign checked_count = r_checked_count;

endmodule

// File: tb/tb_md5_match.sv
// Bench for md5_match: a behavioural md5core stand-in (en-gated delay of digests) feeds the DUT;
// a scoreboard queue of expected search results is checked by an independent monitor.
module tb_md5_match;

    localparam int unsigned LATENCY = 65;
    localparam int unsigned IDX_W   = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             en;
    logic             start;
    logic             mesg_valid;
    logic             mesg_last;
    logic [127:0]     target_hash;
    logic [31:0]      a_in, b_in, c_in, d_in;
    logic             busy;
    logic             match_found;
    logic [IDX_W-1:0] match_index;
    logic             done;
    logic [IDX_W-1:0] checked_count;

    md5_match #(.LATENCY(LATENCY), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .start        (start),
        .mesg_valid   (mesg_valid),
        .mesg_last    (mesg_last),
        .target_hash  (target_hash),
        .a_in         (a_in),
        .b_in         (b_in),
        .c_in         (c_in),
        .d_in         (d_in),
        .busy         (busy),
        .match_found  (match_found),
        .match_index  (match_index),
        .done         (done),
        .checked_count(checked_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // md5core stand-in: the digest of a message accepted at one en edge is on the outputs
    // after LATENCY en edges (counting the accepting edge).
    logic [127:0] cur_digest;
    logic [127:0] pipe [LATENCY];
    always @(posedge clk) begin
        if (en) begin
            for (int i = LATENCY - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= cur_digest;
        end
    end
    assign {a_in, b_in, c_in, d_in} = pipe[LATENCY-1];

    typedef struct {
        bit          found;
        bit          done;
        logic [31:0] idx;
        logic [31:0] cnt;
        bit          busy;
        int          lat;
    } exp_t;

    exp_t exp_q[$];   // expected result at the rising edge of done
    exp_t snap_q[$];  // expected output snapshot at the next sample point

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    bit          prev_done = 1'b0;
    bit          prev_en   = 1'b1;
    bit          prev_rst  = 1'b0;
    logic [31:0] prev_cnt  = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && prev_rst && !prev_en) begin
                chk("count_hold_en0", checked_count, prev_cnt);
            end
            if (reset_n && done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_found", match_found, e.found);
                    chk("done_index", match_index, e.idx);
                    chk("done_count", checked_count, e.cnt);
                    chk("done_busy", busy, 1'b0);
                    if (e.lat >= 0) chk("done_latency", cyc, e.lat);
                end
            end
            if (snap_q.size() != 0) begin
                exp_t s;
                s = snap_q.pop_front();
                chk("snap_found", match_found, s.found);
                chk("snap_done", done, s.done);
                chk("snap_index", match_index, s.idx);
                chk("snap_count", checked_count, s.cnt);
                chk("snap_busy", busy, s.busy);
            end
            prev_done = done;
            prev_en   = en;
            prev_rst  = reset_n;
            prev_cnt  = checked_count;
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_snap(input bit f, input bit d, input logic [31:0] i, input logic [31:0] c,
                             input bit b);
        exp_t s;
        s.found = f; s.done = d; s.idx = i; s.cnt = c; s.busy = b; s.lat = -1;
        snap_q.push_back(s);
    endtask

    // One complete search of n messages (the last carries mesg_last). Positions tpos/tpos2
    // (-1 = unused) get the target digest; every other digest is random.
    task automatic run_search(input int n, input int tpos, input int tpos2,
                              input logic [127:0] target, input bit gaps, input bit chk_lat);
        logic [127:0] digs[$];
        exp_t         e;
        int           i;
        int           k;
        bit           pushed;
        digs.delete();
        for (int j = 0; j < n; j++) digs.push_back(rnd128());
        if (tpos >= 0)  digs[tpos]  = target;
        if (tpos2 >= 0) digs[tpos2] = target;

        // Reference: first message whose digest equals the target, else all n are checked.
        e.found = 1'b0; e.idx = '0; e.cnt = n; e.done = 1'b1; e.busy = 1'b0; e.lat = -1;
        foreach (digs[j]) begin
            if (!e.found && digs[j] == target) begin
                e.found = 1'b1;
                e.idx   = j;
                e.cnt   = j + 1;
            end
        end

        target_hash = target;
        start = 1'b1; en = 1'b1; mesg_valid = 1'b0; mesg_last = 1'b0; cur_digest = rnd128();
        step();
        start = 1'b0;

        i = 0;
        pushed = 1'b0;
        while (i < n) begin
            en         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            mesg_valid = 1'b1;
            mesg_last  = (i == n - 1);
            cur_digest = digs[i];
            if (!pushed && en) begin
                e.lat  = chk_lat ? cyc + LATENCY + 1 : -1;
                exp_q.push_back(e);
                pushed = 1'b1;
            end
            step();
            if (en) i++;
        end
        mesg_valid = 1'b0;
        mesg_last  = 1'b0;

        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            en         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            cur_digest = rnd128();
            step();
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 1'b0, 1'b1);
            exp_q.delete();
        end

        // Let every remaining digest drain; outputs must not move.
        repeat (LATENCY + 10) begin
            en         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            cur_digest = rnd128();
            step();
        end
        en = 1'b1;
        repeat (LATENCY + 2) begin
            cur_digest = rnd128();
            step();
        end
        push_snap(e.found, 1'b1, e.idx, e.cnt, 1'b0);
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] t;
        reset_n = 1'b0; en = 1'b0; start = 1'b0; mesg_valid = 1'b0; mesg_last = 1'b0;
        target_hash = '0; cur_digest = '0;
        repeat (3) step();
        reset_n = 1'b1;
        push_snap(1'b0, 1'b0, '0, '0, 1'b0);
        step();
        step();

        // Single message whose digest is that of the empty string.
        run_search(1, 0, -1, 128'hd41d8cd98f00b204e9800998ecf8427e, 1'b0, 1'b1);

        // Ten messages, match at 6 (and again at 8), last at 9.
        run_search(10, 6, 8, rnd128(), 1'b0, 1'b0);

        // Five messages, target never produced.
        run_search(5, -1, -1, rnd128(), 1'b0, 1'b0);

        // Ten-message scenario with random en gaps.
        run_search(10, 6, 8, rnd128(), 1'b1, 1'b0);

        // Reset mid-search while digests equal to the next target are still in the core.
        t = rnd128();
        target_hash = t;
        start = 1'b1; en = 1'b1; mesg_valid = 1'b0; mesg_last = 1'b0;
        step();
        start = 1'b0;
        repeat (30) begin
            mesg_valid = 1'b1;
            cur_digest = t;
            step();
        end
        mesg_valid = 1'b0;
        reset_n    = 1'b0;
        push_snap(1'b0, 1'b0, '0, '0, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        step();
        run_search(2, 1, -1, t, 1'b0, 1'b0);

        // A few fully random searches.
        for (int r = 0; r < 4; r++) begin
            int n;
            int tp;
            n  = $urandom_range(1, 12);
            tp = $urandom_range(0, n);
            run_search(n, (tp == n) ? -1 : tp, -1, rnd128(), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
